// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared widths, state encoding and saturation constant for the frequency path
package freq_pkg;

   localparam int FREQ_FW = 18;
   localparam int FREQ_PW = 32;

   typedef enum logic {
      IDLE = 1'b0,
      DIV  = 1'b1
   } freq_state_t;

   localparam logic [FREQ_PW-1:0] PHASE_SAT = '1;

endpackage

// File: rtl/freq_div_step.sv
// rtl/freq_div_step.sv - one combinational restoring-division step (shift, compare, subtract)
module freq_div_step #(
   parameter int FW = 18
) (
   input  logic [FW:0]   rem,
   input  logic [FW-1:0] divisor,
   output logic [FW:0]   rem_next,
   output logic          q_bit
);

   logic [FW+1:0] rem2;
   logic [FW+1:0] diff;

   // rem < divisor on entry, so rem2 - divisor always fits back into FW+1 bits
   always_comb begin
      rem2     = {rem, 1'b0};
      diff     = rem2 - {2'b00, divisor};
      q_bit    = (rem2 >= {2'b00, divisor});
      rem_next = q_bit ? diff[FW:0] : rem2[FW:0];
   end

endmodule

// File: rtl/freq_to_phase_inc.sv
// rtl/freq_to_phase_inc.sv - kHz target to NCO phase increment via sequential divider
// Optional round-half-up guard iteration enabled by FREQ_TO_PHASE_ROUND_EN.
module freq_to_phase_inc
   import freq_pkg::*;
#(
   parameter int FW = FREQ_FW,
   parameter int PW = FREQ_PW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [FW-1:0] target_khz,
   input  logic [FW-1:0] sample_freq,
   output logic [PW-1:0] phase_inc,
   output logic          busy,
   output logic          done,
   output logic          valid,
   output logic          sat,
   output logic          err
);

`ifdef FREQ_TO_PHASE_ROUND_EN
   localparam int ITERS = PW + 1;
`else
   localparam int ITERS = PW;
`endif
   localparam int CW = $clog2(ITERS + 1);
   localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

   freq_state_t   state, state_n;
   logic [FW-1:0] divisor, divisor_n;
   logic [FW:0]   rem, rem_n;
   logic [PW-1:0] quot, quot_n, quot_shift;
   logic [CW-1:0] cnt, cnt_n;
   logic [PW-1:0] phase_n;
   logic          busy_n, done_n, valid_n, sat_n, err_n;
   logic [FW:0]   step_rem;
   logic          step_q;
`ifdef FREQ_TO_PHASE_ROUND_EN
   logic [PW:0]   rounded;
`endif

   freq_div_step #(.FW(FW)) u_step (
      .rem      (rem),
      .divisor  (divisor),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         divisor   <= '0;
         rem       <= '0;
         quot      <= '0;
         cnt       <= '0;
         phase_inc <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         valid     <= 1'b0;
         sat       <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         divisor   <= divisor_n;
         rem       <= rem_n;
         quot      <= quot_n;
         cnt       <= cnt_n;
         phase_inc <= phase_n;
         busy      <= busy_n;
         done      <= done_n;
         valid     <= valid_n;
         sat       <= sat_n;
         err       <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      divisor_n  = divisor;
      rem_n      = rem;
      quot_n     = quot;
      cnt_n      = cnt;
      phase_n    = phase_inc;
      busy_n     = busy;
      done_n     = 1'b0;
      valid_n    = valid;
      sat_n      = sat;
      err_n      = err;
      quot_shift = {quot[PW-2:0], step_q};
`ifdef FREQ_TO_PHASE_ROUND_EN
      rounded    = {1'b0, quot} + {{PW{1'b0}}, step_q};
`endif

      case (state)
         IDLE: begin
            if (start) begin
               if (sample_freq == '0) begin
                  err_n  = 1'b1;
                  sat_n  = 1'b0;
                  done_n = 1'b1;
               end else if (target_khz >= sample_freq) begin
                  // ratio >= 1 cannot be represented; decided here so the quotient never wraps
                  phase_n = PHASE_SAT;
                  sat_n   = 1'b1;
                  err_n   = 1'b0;
                  valid_n = 1'b1;
                  done_n  = 1'b1;
               end else begin
                  divisor_n = sample_freq;
                  rem_n     = {1'b0, target_khz};
                  quot_n    = '0;
                  cnt_n     = '0;
                  busy_n    = 1'b1;
                  state_n   = DIV;
               end
            end
         end

         DIV: begin
            rem_n = step_rem;
            cnt_n = cnt + CW'(1);
`ifdef FREQ_TO_PHASE_ROUND_EN
            // final pass is the guard bit: it rounds instead of shifting into the quotient
            if (cnt == LAST) begin
               phase_n = rounded[PW] ? PHASE_SAT : rounded[PW-1:0];
               sat_n   = rounded[PW];
               err_n   = 1'b0;
               valid_n = 1'b1;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end else begin
               quot_n = quot_shift;
            end
`else
            quot_n = quot_shift;
            if (cnt == LAST) begin
               phase_n = quot_shift;
               sat_n   = 1'b0;
               err_n   = 1'b0;
               valid_n = 1'b1;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end
`endif
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_freq_to_phase_inc.sv
// tb/tb_freq_to_phase_inc.sv - randomized and directed checks of freq_to_phase_inc against an arithmetic model
module tb_freq_to_phase_inc;

`ifdef FREQ_TO_PHASE_ROUND_EN
   localparam int LAT = 33;
`else
   localparam int LAT = 32;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [17:0] target_khz = '0;
   logic [17:0] sample_freq = '0;
   logic [31:0] phase_inc;
   logic        busy, done, valid, sat, err;

   int total = 0;
   int bad = 0;

   logic [31:0] m_phase = '0;
   logic        m_valid = 1'b0;

   freq_to_phase_inc dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .target_khz  (target_khz),
      .sample_freq (sample_freq),
      .phase_inc   (phase_inc),
      .busy        (busy),
      .done        (done),
      .valid       (valid),
      .sat         (sat),
      .err         (err)
   );

   always #5 clk = ~clk;

   // floor(t * 2^32 / s), or round-half-up of t * 2^32 / s when rounding is built in
   task automatic model(input logic [17:0] t, input logic [17:0] s,
                        output int e_lat, output logic e_sat, output logic e_err, output logic e_busy);
      longint unsigned tt, ss, q, q33;
      tt = longint'(t);
      ss = longint'(s);
      if (s == 0) begin
         e_err = 1'b1; e_sat = 1'b0; e_lat = 0; e_busy = 1'b0;
      end else if (t >= s) begin
         m_phase = 32'hFFFF_FFFF; m_valid = 1'b1;
         e_err = 1'b0; e_sat = 1'b1; e_lat = 0; e_busy = 1'b0;
      end else begin
`ifdef FREQ_TO_PHASE_ROUND_EN
         q33 = (tt << 33) / ss;
         q   = (q33 >> 1) + (q33 & 64'd1);
`else
         q33 = 0;
         q   = (tt << 32) / ss;
`endif
         e_sat = (q > 64'hFFFF_FFFF);
         m_phase = e_sat ? 32'hFFFF_FFFF : q[31:0];
         m_valid = 1'b1;
         e_err = 1'b0; e_lat = LAT; e_busy = 1'b1;
      end
   endtask

   // drives one start pulse and measures edges from start to done (60 = timed out)
   task automatic do_conv(input logic [17:0] t, input logic [17:0] s,
                          output int lat, output logic busy_first);
      @(negedge clk);
      target_khz = t; sample_freq = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy_first = busy;
      lat = 0;
      while (!done && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total += 6;
      if (phase_inc !== 32'h0) begin bad++; $display("FAIL reset_phase got=%h want=0", phase_inc); end
      if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
      if (sat !== 1'b0)   begin bad++; $display("FAIL reset_sat got=%b want=0", sat); end
      if (err !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b want=0", err); end
      reset = 1'b0;
      m_phase = '0; m_valid = 1'b0;
   endtask

   task automatic test_directed();
      int lat, e_lat;
      logic b0, e_sat, e_err, e_busy;
      logic [31:0] want;

      model(18'd25000, 18'd50000, e_lat, e_sat, e_err, e_busy);
      do_conv(18'd25000, 18'd50000, lat, b0);
      total += 5;
      if (b0 !== 1'b1)  begin bad++; $display("FAIL half_busy got=%b want=1", b0); end
      if (lat != LAT)   begin bad++; $display("FAIL half_latency got=%0d want=%0d", lat, LAT); end
      if (phase_inc !== 32'h8000_0000) begin bad++; $display("FAIL half_phase got=%h want=80000000", phase_inc); end
      if (valid !== 1'b1) begin bad++; $display("FAIL half_valid got=%b want=1", valid); end
      if (sat !== 1'b0)   begin bad++; $display("FAIL half_sat got=%b want=0", sat); end
      @(negedge clk);
      total += 2;
      if (done !== 1'b0) begin bad++; $display("FAIL done_single_cycle got=%b want=0", done); end
      if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end

`ifdef FREQ_TO_PHASE_ROUND_EN
      want = 32'h1999_999A;
`else
      want = 32'h1999_9999;
`endif
      model(18'd5000, 18'd50000, e_lat, e_sat, e_err, e_busy);
      do_conv(18'd5000, 18'd50000, lat, b0);
      total += 2;
      if (lat != LAT) begin bad++; $display("FAIL tenth_latency got=%0d want=%0d", lat, LAT); end
      if (phase_inc !== want) begin bad++; $display("FAIL tenth_phase got=%h want=%h", phase_inc, want); end

      model(18'd0, 18'd1000, e_lat, e_sat, e_err, e_busy);
      do_conv(18'd0, 18'd1000, lat, b0);
      total += 3;
      if (lat != LAT) begin bad++; $display("FAIL zero_latency got=%0d want=%0d", lat, LAT); end
      if (phase_inc !== 32'h0) begin bad++; $display("FAIL zero_phase got=%h want=0", phase_inc); end
      if (valid !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b want=1", valid); end
   endtask

   task automatic test_err_sat();
      int lat, e_lat;
      logic b0, e_sat, e_err, e_busy;

      model(18'd12345, 18'd40000, e_lat, e_sat, e_err, e_busy);
      do_conv(18'd12345, 18'd40000, lat, b0);
      model(18'd777, 18'd0, e_lat, e_sat, e_err, e_busy);
      do_conv(18'd777, 18'd0, lat, b0);
      total += 6;
      if (lat != 0)     begin bad++; $display("FAIL err_latency got=%0d want=0", lat); end
      if (b0 !== 1'b0)  begin bad++; $display("FAIL err_busy got=%b want=0", b0); end
      if (err !== 1'b1) begin bad++; $display("FAIL err_flag got=%b want=1", err); end
      if (sat !== 1'b0) begin bad++; $display("FAIL err_sat got=%b want=0", sat); end
      if (phase_inc !== m_phase) begin bad++; $display("FAIL err_phase_held got=%h want=%h", phase_inc, m_phase); end
      if (valid !== m_valid) begin bad++; $display("FAIL err_valid_held got=%b want=%b", valid, m_valid); end

      model(18'd50000, 18'd50000, e_lat, e_sat, e_err, e_busy);
      do_conv(18'd50000, 18'd50000, lat, b0);
      total += 5;
      if (lat != 0)     begin bad++; $display("FAIL sat_latency got=%0d want=0", lat); end
      if (b0 !== 1'b0)  begin bad++; $display("FAIL sat_busy got=%b want=0", b0); end
      if (phase_inc !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_phase got=%h want=ffffffff", phase_inc); end
      if (sat !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b want=1", sat); end
      if (err !== 1'b0) begin bad++; $display("FAIL sat_err got=%b want=0", err); end
   endtask

   task automatic test_ignore_start();
      int lat, e_lat;
      logic b0, e_sat, e_err, e_busy;

      model(18'd5000, 18'd50000, e_lat, e_sat, e_err, e_busy);
      @(negedge clk);
      target_khz = 18'd5000; sample_freq = 18'd50000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 60) begin
         if (lat == 10) begin
            start = 1'b1; target_khz = 18'd1; sample_freq = 18'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      total += 2;
      if (lat != LAT) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, LAT); end
      if (phase_inc !== m_phase) begin bad++; $display("FAIL ignore_phase got=%h want=%h", phase_inc, m_phase); end
   endtask

   task automatic test_reset_mid();
      int lat, e_lat;
      logic b0, e_sat, e_err, e_busy;

      @(negedge clk);
      target_khz = 18'd30000; sample_freq = 18'd70000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_phase = '0; m_valid = 1'b0;
      total += 4;
      if (busy !== 1'b0)  begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
      if (valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", valid); end
      if (phase_inc !== 32'h0) begin bad++; $display("FAIL abort_phase got=%h want=0", phase_inc); end
      if (done !== 1'b0)  begin bad++; $display("FAIL abort_done got=%b want=0", done); end

      model(18'd30000, 18'd70000, e_lat, e_sat, e_err, e_busy);
      do_conv(18'd30000, 18'd70000, lat, b0);
      total += 2;
      if (lat != LAT) begin bad++; $display("FAIL after_abort_latency got=%0d want=%0d", lat, LAT); end
      if (phase_inc !== m_phase) begin bad++; $display("FAIL after_abort_phase got=%h want=%h", phase_inc, m_phase); end
   endtask

   task automatic test_random();
      int lat, e_lat, mode;
      logic b0, e_sat, e_err, e_busy;
      logic [17:0] t, s;

      for (int i = 0; i < 24; i++) begin
         mode = int'($urandom_range(0, 9));
         if (mode == 0) begin
            s = '0;
            t = 18'($urandom);
         end else begin
            s = 18'($urandom_range(1, 262143));
            if (mode == 1) t = 18'($urandom_range(int'(s), 262143));
            else           t = 18'($urandom_range(0, int'(s) - 1));
         end
         model(t, s, e_lat, e_sat, e_err, e_busy);
         do_conv(t, s, lat, b0);
         total += 6;
         if (lat != e_lat) begin bad++; $display("FAIL rnd_latency t=%0d s=%0d got=%0d want=%0d", t, s, lat, e_lat); end
         if (b0 !== e_busy) begin bad++; $display("FAIL rnd_busy t=%0d s=%0d got=%b want=%b", t, s, b0, e_busy); end
         if (phase_inc !== m_phase) begin bad++; $display("FAIL rnd_phase t=%0d s=%0d got=%h want=%h", t, s, phase_inc, m_phase); end
         if (valid !== m_valid) begin bad++; $display("FAIL rnd_valid t=%0d s=%0d got=%b want=%b", t, s, valid, m_valid); end
         if (sat !== e_sat) begin bad++; $display("FAIL rnd_sat t=%0d s=%0d got=%b want=%b", t, s, sat, e_sat); end
         if (err !== e_err) begin bad++; $display("FAIL rnd_err t=%0d s=%0d got=%b want=%b", t, s, err, e_err); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_err_sat();
      test_ignore_start();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
